fp_to_int_converter: RTL and testbench
======================================

Name: fp_to_int_converter

Overview:
- Iterative FP32-to-integer converter. It is the reverse direction of the FP adder's pack stage: it unpacks a single-precision operand, shifts the mantissa into integer position and rounds to a signed or unsigned 32-bit integer.
- It sits beside the FP adder in the ALU and uses the same 3-bit r_mode encoding.
- Input and output use valid/ready handshakes. The mantissa shift runs over multiple cycles to keep the shifter small.

Parameters:
SHIFT_STEP, 4, maximum left-shift bit positions per SHIFT cycle (1..32).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  operand valid
in_ready  out  1  converter can accept (high only in IDLE)
fp_a  in  32  FP32 operand
r_mode  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 behave as RNE
is_signed  in  1  1: signed int32 result, 0: unsigned uint32
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
int_result  out  32  converted integer
invalid  out  1  NaN, infinity, or out-of-range result
inexact  out  1  discarded fraction was nonzero (never set together with invalid)

Behaviour:
- Reset: one clock domain; rst_n is asynchronous, active-low. rst_n low forces state IDLE, out_valid=0, int_result=0, invalid=0, inexact=0, in_ready=1. This applies mid-operation too: the in-flight operand is discarded and no output is produced.
- FSM states: IDLE, SHIFT, ROUND, DONE.
- IDLE: accept on in_valid&&in_ready. Latch sign, fp_a, r_mode, is_signed. Unpack exp e=fp_a[30:23], mant={|e, fp_a[22:0]}, E=e-127.
  - e==FF: special → ROUND.
  - E>=32: overflow → ROUND.
  - E<0: acc integer part=0. guard=(E==-1). sticky = (E==-1) ? |fp_a[22:0] : (fp_a[30:0]!=0). → ROUND.
  - 0<=E<=31: acc[55:0]={32'b0, mant}, cnt=E+1 → SHIFT.
- Accumulator layout: integer part = acc[55:24], guard = acc[23], sticky = |acc[22:0].
- SHIFT: each cycle acc <<= min(cnt, SHIFT_STEP) and cnt -= the same amount. Go to ROUND in the cycle cnt reaches 0.
- ROUND: compute inc from lsb=acc[24], g, s, sign:
  - RNE: inc = g&(s|lsb)
  - RTZ: inc = 0
  - RDN: inc = (g|s)&sign
  - RUP: inc = (g|s)&!sign
  - RMM: inc = g
  - Magnitude is 33 bits: {1'b0, acc[55:24]} + inc.
- Saturation, signed:
  - mag > 2^31-1 with sign=0, or mag > 2^31 with sign=1 → invalid.
  - Saturate to 0x7FFFFFFF (positive) or 0x80000000 (negative).
  - Otherwise result is ±mag in two's complement.
- Saturation, unsigned:
  - sign=1 and mag!=0 → invalid, 0x00000000.
  - mag > 2^32-1 → invalid, 0xFFFFFFFF.
  - Negative input that rounds to 0 → result 0, not invalid.
- Specials:
  - NaN (any payload): signed 0x7FFFFFFF, unsigned 0xFFFFFFFF.
  - +inf: same values as NaN.
  - -inf: signed 0x80000000, unsigned 0.
  - All specials set invalid.
  - E>=32 follows the sign-based saturation rules above.
- Zeros: ±0 → 0, no flags.
- inexact = (g|s) && !invalid. Registered in ROUND together with int_result.
- DONE: out_valid=1. int_result and flags are held stable until out_valid&&out_ready, then → IDLE.
- in_ready=0 in SHIFT, ROUND and DONE. No input is accepted in the same cycle as the output handshake.
- Latency from accept edge to out_valid rising = 2 + ceil(cnt/SHIFT_STEP) edges, with cnt=0 on non-shift paths.
- in_valid, fp_a, r_mode and is_signed are ignored outside IDLE.

Test Plan:
1. fp_a=0x40490FDB (3.14159), signed, RNE, SHIFT_STEP=4 → int_result=3, inexact=1, invalid=0; out_valid rises 3 edges after accept.
2. 0x40200000 (2.5): RNE→2, RMM→3, RUP→3, RTZ→2. 0xC0200000 (-2.5): RDN→0xFFFFFFFD. All set inexact=1.
3. Signed 0x4F000000 (2^31) → 0x7FFFFFFF, invalid=1. Signed 0xCF000000 → 0x80000000, no flags, out_valid 10 edges after accept. Unsigned 0x4F800000 (2^32) → 0xFFFFFFFF, invalid=1.
4. Unsigned cases:
   - 0xBE99999A (-0.3), RTZ → 0, inexact=1, invalid=0.
   - Same operand, RDN → 0, invalid=1, inexact=0.
   - 0xBF800000 (-1.0) → 0, invalid=1.
5. Specials:
   - 0x7FC00000 signed → 0x7FFFFFFF, invalid=1.
   - 0xFF800000 unsigned → 0, invalid=1.
   - 0x00000001 (subnormal), RUP → 1, inexact=1.
   - 0x80000000 → 0, no flags.
6. Handshake and reset:
   - Hold out_ready=0 for 5 cycles in DONE → result and flags stable, in_ready=0. Release → one handshake, back to IDLE.
   - Drop rst_n during SHIFT → out_valid=0 and in_ready=1 immediately, with no clock edge needed.

Source files
------------

// File: rtl/fp_to_int_converter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp_to_int_converter_if
//  Description : Handshake bundle for the FP32-to-integer converter.
//                Input side : in_valid/in_ready, fp_a, r_mode, is_signed
//                Output side: out_valid/out_ready, int_result, invalid, inexact
//                master = operand producer / result consumer
//                slave  = converter
//  Revision    : 1.0 - initial release
// ============================================================================
interface fp_to_int_converter_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] fp_a;
    logic [2:0]  r_mode;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] int_result;
    logic        invalid;
    logic        inexact;

    modport master (
        output in_valid, fp_a, r_mode, is_signed, out_ready,
        input  in_ready, out_valid, int_result, invalid, inexact
    );

    modport slave (
        input  in_valid, fp_a, r_mode, is_signed, out_ready,
        output in_ready, out_valid, int_result, invalid, inexact
    );
endinterface
`default_nettype wire

// File: rtl/fp_to_int_converter.sv
`default_nettype none
// ============================================================================
//  Module      : fp_to_int_converter
//  Description : Iterative FP32 -> int32/uint32 converter. Unpacks the
//                operand, shifts the mantissa into integer position at most
//                SHIFT_STEP bits per cycle, then rounds and saturates.
//  Ports       : clk   - clock
//                rst_n - asynchronous active-low reset
//                bus   - fp_to_int_converter_if.slave (operand in / result out)
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_to_int_converter #(
    parameter int SHIFT_STEP = 4
) (
    input  wire                          clk,
    input  wire                          rst_n,
    fp_to_int_converter_if.slave         bus
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_ROUND = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [5:0] c_STEP = 6'(SHIFT_STEP);

    logic [1:0]  r_state;
    logic        r_sign;
    logic [2:0]  r_rmode;
    logic        r_signed;
    logic        r_sat;       // NaN, infinity or |x| >= 2^32: result saturates
    logic        r_sat_neg;   // saturate toward the negative end (NaN never does)
    logic [55:0] r_acc;       // [55:24] integer, [23] guard, [22:0] sticky bits
    logic [5:0]  r_cnt;
    logic [31:0] r_result;
    logic        r_invalid;
    logic        r_inexact;

    // Unpack
    logic [7:0]  w_exp;
    logic [23:0] w_mant;
    logic        w_exp_max;
    logic        w_frac_nz;

    assign w_exp     = bus.fp_a[30:23];
    assign w_mant    = {|w_exp, bus.fp_a[22:0]};
    assign w_exp_max = (w_exp == 8'hFF);
    assign w_frac_nz = |bus.fp_a[22:0];

    // Shift step: min(cnt, SHIFT_STEP)
    logic [5:0] w_step;
    assign w_step = (r_cnt < c_STEP) ? r_cnt : c_STEP;

    // Rounding and saturation
    logic        w_g;
    logic        w_s;
    logic        w_inc;
    logic [32:0] w_mag;
    logic [31:0] w_res;
    logic        w_inv;
    logic        w_inx;

    always_comb begin
        w_g   = r_acc[23];
        w_s   = |r_acc[22:0];
        case (r_rmode)
            3'b001:  w_inc = 1'b0;                          // RTZ
            3'b010:  w_inc = (w_g | w_s) & r_sign;          // RDN
            3'b011:  w_inc = (w_g | w_s) & ~r_sign;         // RUP
            3'b100:  w_inc = w_g;                           // RMM
            default: w_inc = w_g & (w_s | r_acc[24]);       // RNE
        endcase
        w_mag = {1'b0, r_acc[55:24]} + {32'd0, w_inc};
        w_res = w_mag[31:0];
        w_inv = 1'b0;
        if (r_sat) begin
            w_inv = 1'b1;
            if (r_signed) w_res = r_sat_neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
            else          w_res = r_sat_neg ? 32'h0000_0000 : 32'hFFFF_FFFF;
        end else if (r_signed) begin
            if (!r_sign && (w_mag > 33'h0_7FFF_FFFF)) begin
                w_inv = 1'b1;
                w_res = 32'h7FFF_FFFF;
            end else if (r_sign && (w_mag > 33'h0_8000_0000)) begin
                w_inv = 1'b1;
                w_res = 32'h8000_0000;
            end else if (r_sign) begin
                w_res = -w_mag[31:0];
            end
        end else begin
            // A negative value that rounds to zero is a legal unsigned 0
            if (r_sign && (w_mag != 33'd0)) begin
                w_inv = 1'b1;
                w_res = 32'h0000_0000;
            end else if (w_mag[32]) begin
                w_inv = 1'b1;
                w_res = 32'hFFFF_FFFF;
            end
        end
        w_inx = (w_g | w_s) & ~w_inv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_sign    <= 1'b0;
            r_rmode   <= 3'd0;
            r_signed  <= 1'b0;
            r_sat     <= 1'b0;
            r_sat_neg <= 1'b0;
            r_acc     <= 56'd0;
            r_cnt     <= 6'd0;
            r_result  <= 32'd0;
            r_invalid <= 1'b0;
            r_inexact <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_sign    <= bus.fp_a[31];
                        r_rmode   <= bus.r_mode;
                        r_signed  <= bus.is_signed;
                        r_sat     <= w_exp_max || (w_exp >= 8'd159);
                        r_sat_neg <= bus.fp_a[31] && !(w_exp_max && w_frac_nz);
                        r_cnt     <= 6'd0;
                        r_state   <= c_ST_ROUND;
                        if (w_exp_max || (w_exp >= 8'd159)) begin
                            r_acc <= 56'd0;
                        end else if (w_exp < 8'd127) begin
                            // |x| < 1: only guard and sticky survive
                            if (w_exp == 8'd126)
                                r_acc <= {32'd0, 1'b1, 22'd0, w_frac_nz};
                            else
                                r_acc <= {32'd0, 1'b0, 22'd0, |bus.fp_a[30:0]};
                        end else begin
                            r_acc   <= {32'd0, w_mant};
                            // cnt = e - 126; mod 64 that is e[5:0] + 2
                            r_cnt   <= w_exp[5:0] + 6'd2;
                            r_state <= c_ST_SHIFT;
                        end
                    end
                end
                c_ST_SHIFT: begin
                    r_acc <= r_acc << w_step;
                    r_cnt <= r_cnt - w_step;
                    if (r_cnt == w_step) r_state <= c_ST_ROUND;
                end
                c_ST_ROUND: begin
                    r_result  <= w_res;
                    r_invalid <= w_inv;
                    r_inexact <= w_inx;
                    r_state   <= c_ST_DONE;
                end
                default: begin
                    if (bus.out_ready) r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = (r_state == c_ST_IDLE);
    assign bus.out_valid  = (r_state == c_ST_DONE);
    assign bus.int_result = r_result;
    assign bus.invalid    = r_invalid;
    assign bus.inexact    = r_inexact;

endmodule
`default_nettype wire

// File: tb/tb_fp_to_int_converter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_to_int_converter
//  Description : Directed-vector bench for fp_to_int_converter (SHIFT_STEP=4)
//                with hand-computed results, flags and latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_to_int_converter;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    fp_to_int_converter_if bus ();

    fp_to_int_converter #(.SHIFT_STEP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply one operand, check latency, result and flags; optionally hold
    // out_ready low for 'hold' cycles in DONE before completing the handshake.
    task automatic run_op(input string tag, input logic [31:0] fp, input logic [2:0] rm,
                          input logic sg, input logic [31:0] exp_res, input logic exp_inv,
                          input logic exp_inx, input int exp_lat, input int hold);
        int lat;
        @(negedge clk);
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.fp_a      = fp;
        bus.r_mode    = rm;
        bus.is_signed = sg;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(posedge clk); #1;
        // Scramble inputs: they must be ignored while busy
        bus.in_valid  = 1'b0;
        bus.fp_a      = 32'hDEAD_BEEF;
        bus.r_mode    = ~rm;
        bus.is_signed = ~sg;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, bus.int_result, exp_res);
        check({tag, " invalid"}, 32'(bus.invalid), 32'(exp_inv));
        check({tag, " inexact"}, 32'(bus.inexact), 32'(exp_inx));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
            check({tag, " hold result"}, bus.int_result, exp_res);
            check({tag, " hold flags"}, {30'd0, bus.invalid, bus.inexact}, {30'd0, exp_inv, exp_inx});
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " post valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, " post in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int  guard;
        logic seen_valid;
        n_vec = 0;
        n_err = 0;
        bus.in_valid  = 1'b0;
        bus.fp_a      = 32'd0;
        bus.r_mode    = 3'd0;
        bus.is_signed = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset int_result", bus.int_result, 32'd0);
        check("reset flags", {30'd0, bus.invalid, bus.inexact}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //      tag         fp_a          rm    sg    result         inv   inx  lat hold
        run_op("pi",        32'h40490FDB, 3'd0, 1'b1, 32'd3,         1'b0, 1'b1, 3, 0);
        run_op("2.5 rne",   32'h40200000, 3'd0, 1'b1, 32'd2,         1'b0, 1'b1, 3, 0);
        run_op("2.5 rmm",   32'h40200000, 3'd4, 1'b1, 32'd3,         1'b0, 1'b1, 3, 0);
        run_op("2.5 rup",   32'h40200000, 3'd3, 1'b1, 32'd3,         1'b0, 1'b1, 3, 0);
        run_op("2.5 rtz",   32'h40200000, 3'd1, 1'b1, 32'd2,         1'b0, 1'b1, 3, 0);
        run_op("2.5 rm7",   32'h40200000, 3'd7, 1'b1, 32'd2,         1'b0, 1'b1, 3, 0);
        run_op("-2.5 rdn",  32'hC0200000, 3'd2, 1'b1, 32'hFFFFFFFD,  1'b0, 1'b1, 3, 0);
        run_op("1.5 rne",   32'h3FC00000, 3'd0, 1'b1, 32'd2,         1'b0, 1'b1, 3, 0);
        run_op("0.5 rne",   32'h3F000000, 3'd0, 1'b1, 32'd0,         1'b0, 1'b1, 2, 0);
        run_op("2^31 s",    32'h4F000000, 3'd0, 1'b1, 32'h7FFFFFFF,  1'b1, 1'b0, 10, 0);
        run_op("-2^31 s",   32'hCF000000, 3'd0, 1'b1, 32'h80000000,  1'b0, 1'b0, 10, 0);
        run_op("<-2^31 s",  32'hCF000001, 3'd0, 1'b1, 32'h80000000,  1'b1, 1'b0, 10, 0);
        run_op("maxpos s",  32'h4EFFFFFF, 3'd0, 1'b1, 32'h7FFFFF80,  1'b0, 1'b0, 10, 0);
        run_op("2^32 u",    32'h4F800000, 3'd0, 1'b0, 32'hFFFFFFFF,  1'b1, 1'b0, 2, 0);
        run_op("maxpos u",  32'h4F7FFFFF, 3'd0, 1'b0, 32'hFFFFFF00,  1'b0, 1'b0, 10, 0);
        run_op("-0.3 rtz u",32'hBE99999A, 3'd1, 1'b0, 32'd0,         1'b0, 1'b1, 2, 0);
        run_op("-0.3 rdn u",32'hBE99999A, 3'd2, 1'b0, 32'd0,         1'b1, 1'b0, 2, 0);
        run_op("-1.0 u",    32'hBF800000, 3'd0, 1'b0, 32'd0,         1'b1, 1'b0, 3, 0);
        run_op("qnan s",    32'h7FC00000, 3'd0, 1'b1, 32'h7FFFFFFF,  1'b1, 1'b0, 2, 0);
        run_op("-nan u",    32'hFFC00001, 3'd0, 1'b0, 32'hFFFFFFFF,  1'b1, 1'b0, 2, 0);
        run_op("-inf u",    32'hFF800000, 3'd0, 1'b0, 32'd0,         1'b1, 1'b0, 2, 0);
        run_op("-inf s",    32'hFF800000, 3'd0, 1'b1, 32'h80000000,  1'b1, 1'b0, 2, 0);
        run_op("subn rup",  32'h00000001, 3'd3, 1'b1, 32'd1,         1'b0, 1'b1, 2, 0);
        run_op("-0",        32'h80000000, 3'd0, 1'b1, 32'd0,         1'b0, 1'b0, 2, 0);
        run_op("stall",     32'h40200000, 3'd3, 1'b1, 32'd3,         1'b0, 1'b1, 3, 5);

        // Asynchronous reset in the middle of a SHIFT sequence
        @(negedge clk);
        bus.fp_a      = 32'h4EFFFFFF;
        bus.r_mode    = 3'd0;
        bus.is_signed = 1'b1;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #2;
        check("mid in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        check("rst int_result", bus.int_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (guard = 0; guard < 15; guard++) begin
            @(posedge clk); #1;
            seen_valid = seen_valid | bus.out_valid;
        end
        check("rst no output", 32'(seen_valid), 32'd0);
        run_op("after rst", 32'h3FC00000, 3'd0, 1'b1, 32'd2, 1'b0, 1'b1, 3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
